// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-and-add multiplier.
// State encodings are fixed binary so the state register width is 2.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int STATE_BITS    = 2;

  typedef enum logic [STATE_BITS-1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } mult_state_t;

endpackage

// File: rtl/mult_fsm_state_reg.sv
// N-bit state register built from independent per-bit flops.
// Asynchronous active-low reset clears every bit.
module state_reg #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] next_state,
  output logic [N-1:0] state
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) state[i] <= 1'b0;
      else        state[i] <= next_state[i];
    end
  end

endmodule

// File: rtl/mult_fsm.sv
// Sequential unsigned shift-and-add multiplier, WIDTH iterations.
// Moore controller with outputs decoded from the registered state.
module mult_fsm
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH + 1;

  logic [STATE_BITS-1:0] state_q;
  mult_state_t           state;
  mult_state_t           next_state;

  logic [WIDTH-1:0]   a_reg;
  logic [AW-1:0]      acc;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;
  logic               last;

  state_reg #(
    .N(STATE_BITS)
  ) u_state (
    .clk        (clk),
    .reset      (reset),
    .next_state (next_state),
    .state      (state_q)
  );

  assign state = mult_state_t'(state_q);

  assign last    = (count == CW'(WIDTH - 1));
  assign addend  = acc[0] ? {1'b0, a_reg} : '0;
  assign sum     = acc[2*WIDTH:WIDTH] + addend;
  assign shifted = {sum, acc[WIDTH-1:1]};

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: next_state = start ? S_LOAD : S_IDLE;
      S_LOAD: next_state = S_RUN;
      S_RUN:  next_state = last ? S_DONE : S_RUN;
      S_DONE: next_state = S_IDLE;
    endcase
  end

  assign busy = (state == S_LOAD) || (state == S_RUN);
  assign done = (state == S_DONE);

  // Carry lands in sum[WIDTH]; the zero above it keeps acc's MSB clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          a_reg <= multiplicand;
          acc   <= {{(WIDTH+1){1'b0}}, multiplier};
          count <= '0;
        end
        S_RUN: begin
          acc   <= {1'b0, shifted};
          count <= count + CW'(1);
          if (last) product <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_fsm.sv
// Directed bench for mult_fsm at WIDTH=4.
// Hand-computed products, latencies and pulse counts.
module tb_mult_fsm;
  import mult_pkg::*;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  mult_fsm #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from a single start pulse; i counts samples after E0+i.
  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp,
                        input bit inject);
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    logic [2*W-1:0] p = '0;
    @(negedge clk);
    multiplicand = a;
    multiplier = b;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start = 1'b0;
      if (inject && i == 2) begin
        start = 1'b1;
        multiplicand = a + 4'd5;
        multiplier = b + 4'd3;
      end
      if (inject && i == 3) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = i;
        p = product;
      end
    end
    chk({tag, "_busy_cycles"}, busy_n, 5);
    chk({tag, "_done_count"}, done_n, 1);
    chk({tag, "_done_at"}, done_at, W + 1);
    chk({tag, "_product"}, p, exp);
    chk({tag, "_held"}, product, exp);
    chk({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin : main
    int dn;
    int d_at[$];
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_product", product, 8'h00);
    chk("rst_state", dut.state_q, S_IDLE);
    @(negedge clk);
    reset = 1'b1;

    run_op("a3_b5", 4'd3, 4'd5, 8'h0F, 1'b0);
    run_op("af_bf", 4'hF, 4'hF, 8'hE1, 1'b0);
    run_op("a0_b9", 4'd0, 4'd9, 8'h00, 1'b0);
    run_op("a9_b0", 4'd9, 4'd0, 8'h00, 1'b0);
    run_op("a7_bb_inj", 4'd7, 4'd11, 8'h4D, 1'b1);

    // Abort in the middle of RUN, between clock edges.
    @(negedge clk);
    multiplicand = 4'd3;
    multiplier = 4'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_run_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_product", product, 8'h00);
    chk("abort_state", dut.state_q, S_IDLE);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op("a2_b7", 4'd2, 4'd7, 8'h0E, 1'b0);

    // Start held high: back-to-back ops every W+3 cycles.
    @(negedge clk);
    multiplicand = 4'd6;
    multiplier = 4'd6;
    start = 1'b1;
    dn = 0;
    for (int i = 0; i < 26; i++) begin
      @(posedge clk);
      #1;
      if (i == 19) start = 1'b0;
      if (done) begin
        dn++;
        d_at.push_back(i);
        chk("b2b_product", product, 8'h24);
      end
    end
    chk("b2b_done_count", dn, 3);
    chk("b2b_first", (d_at.size() > 0) ? d_at[0] : -1, 5);
    chk("b2b_second", (d_at.size() > 1) ? d_at[1] : -1, 12);
    chk("b2b_third", (d_at.size() > 2) ? d_at[2] : -1, 19);
    chk("b2b_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_fsm.md
# mult_fsm

Sequential shift-and-add unsigned multiplier: a Moore state machine plus a small datapath that computes `multiplicand * multiplier` over WIDTH iterations. Its state register consumes the per-bit next-state logic and feeds it into a bank of D flip-flops, one per state bit. It is the next-state/controller stage that sits upstream of those flops. It also serves as the first multi-cycle arithmetic block in the design.

## Interface
- `WIDTH`, default 4, operand width in bits; legal range 2–16.
- `clk`  in  1  system clock; all state changes occur on its rising edge.
- `reset`  in  1  asynchronous, active-low; `0` forces reset state immediately, independent of `clk`.
- `start`  in  1  request; sampled only in IDLE.
- `multiplicand`  in  WIDTH  operand A, unsigned.
- `multiplier`  in  WIDTH  operand B, unsigned.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  high for exactly one cycle, in DONE.
- `product`  out  2*WIDTH  result; valid from DONE until the next LOAD.

## Operation
- States, 2-bit binary encoding: IDLE=00, LOAD=01, RUN=10, DONE=11.
- Transitions:
  - IDLE→LOAD when `start`=1; otherwise stay in IDLE.
  - LOAD→RUN unconditionally.
  - RUN→RUN while `count` < WIDTH-1; RUN→DONE on the iteration where `count` = WIDTH-1.
  - DONE→IDLE unconditionally.
- LOAD actions:
  - `a_reg` ← `multiplicand`.
  - `acc` ← {(WIDTH+1)'b0, `multiplier`}.
  - `count` ← 0.
- RUN iteration:
  - Compute `sum` = `acc`[2W:W] + (`acc`[0] ? {1'b0,`a_reg`} : 0), a (WIDTH+1)-bit add.
  - `acc` ← {`sum`, `acc`[W-1:1]}, i.e. a logical right shift by 1 with the carry retained.
  - `count` ← `count`+1.
- `acc` width is 2*WIDTH+1. `product` = `acc`[2W-1:0], registered. The top bit of `acc` is always 0 after the final shift.
- `count` width is clog2(WIDTH)+1; it never wraps within an operation.
- `start` is ignored in LOAD, RUN and DONE. It causes no queueing and no restart.
- Operands are captured in LOAD only. Operand changes during RUN have no effect.
- If `start` is held high continuously, operations run back to back, one per WIDTH+3 cycles (the IDLE cycle is included).
- Zero operands take the same path and latency as any other values; there is no early exit.

## Timing
- Reset (`reset`=0) sets the following, asynchronously:
  - state=IDLE
  - `busy`=0
  - `done`=0
  - `product`=0
  - `acc`=0
  - `a_reg`=0
  - `count`=0
- Reset asserted mid-operation aborts the operation; no `done` is produced. The first `start` after `reset` returns high behaves as if from power-up.
- Deassertion of `reset` takes effect at the first rising edge of `clk` after release.
- Outputs are Moore: decoded from registered state only, with no combinational path from `start` to `busy` or `done`.
- Latency, with `start` sampled at edge E0:
  - After E0: LOAD.
  - After E1: RUN.
  - After E(1+WIDTH): DONE, with `done`=1 and `product` valid.
  - After E(2+WIDTH): IDLE.
- For WIDTH=4, `done` is high between edges E5 and E6.

## Structure
- Shared package `mult_pkg`:
  - state typedef `mult_state_t`
  - state encodings `S_IDLE`, `S_LOAD`, `S_RUN`, `S_DONE`
  - default `WIDTH`
- One sub-module, `state_reg`: an N-bit register built from per-bit flip-flops. It has asynchronous active-low `reset` and `next_state[N-1:0]` in, and `state[N-1:0]` out.
- `mult_fsm` contains the next-state logic, the output decode and the datapath registers (`a_reg`, `acc`, `count`).

## Test plan
- WIDTH=4, A=3, B=5, single `start` pulse → `busy` high 5 cycles, `done` pulse after E5, `product`=0x0F.
- A=0xF, B=0xF → `product`=0xE1. The carry is exercised on every add.
- A=0, B=9, and separately A=9, B=0 → `product`=0x00 in each case, with the same latency as the first scenario.
- Pulse `start` during RUN with different operands → no effect; the original result is unchanged, and exactly one `done` is produced.
- Assert `reset`=0 in the middle of RUN, between clock edges → all outputs 0 immediately, state is IDLE, and no `done` is produced. A new `start` with A=2, B=7 → `product`=0x0E.
- Hold `start`=1 for 20 cycles with A=6, B=6 → `done` pulses every 7 cycles, and `product`=0x24 each time.
